// File: rtl/turf_udp_pkg.sv
// Shared types and widths for the UDP transmit path.
package turf_udp_pkg;

    localparam int unsigned UDP_HDR_W  = 64;
    localparam int unsigned UDP_DATA_W = 64;
    localparam int unsigned UDP_KEEP_W = 8;

    typedef struct packed {
        logic [31:0] ip;
        logic [15:0] port;
        logic [15:0] length;
    } udp_hdr_t;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA
    } tx_state_e;

endpackage

// File: rtl/turf_udp_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester strictly above the last winner, cyclically.
module rr_arbiter #(
    parameter  int unsigned N  = 2,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt_c,
    output logic [IW-1:0] idx_c
);

    logic        found;
    int unsigned cand;

    always_comb begin
        gnt_c = '0;
        idx_c = '0;
        found = 1'b0;
        cand  = 0;
        // Offsets 1..N visit every requester once, ending on last itself.
        for (int unsigned k = 1; k <= N; k++) begin
            cand = (32'(last) + k) % N;
            if (!found && req[cand[IW-1:0]]) begin
                found                = 1'b1;
                gnt_c[cand[IW-1:0]]  = 1'b1;
                idx_c                = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/turf_udp_tx_arbiter.sv
// Round-robin arbiter sharing one UDP TX path (header + payload) among NREQ engines.
// A grant is held for one header beat plus payload beats up to tlast.
module turf_udp_tx_arbiter
    import turf_udp_pkg::*;
#(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned CNT_BITS = 16
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [NREQ*UDP_HDR_W-1:0]  s_udphdr_tdata,
    input  logic [NREQ-1:0]            s_udphdr_tvalid,
    output logic [NREQ-1:0]            s_udphdr_tready,
    input  logic [NREQ*UDP_DATA_W-1:0] s_udpdata_tdata,
    input  logic [NREQ*UDP_KEEP_W-1:0] s_udpdata_tkeep,
    input  logic [NREQ-1:0]            s_udpdata_tlast,
    input  logic [NREQ-1:0]            s_udpdata_tvalid,
    output logic [NREQ-1:0]            s_udpdata_tready,
    output logic [UDP_HDR_W-1:0]       m_udphdr_tdata,
    output logic                       m_udphdr_tvalid,
    input  logic                       m_udphdr_tready,
    output logic [UDP_DATA_W-1:0]      m_udpdata_tdata,
    output logic [UDP_KEEP_W-1:0]      m_udpdata_tkeep,
    output logic                       m_udpdata_tlast,
    output logic                       m_udpdata_tvalid,
    input  logic                       m_udpdata_tready,
    output logic [NREQ-1:0]            grant_o,
    output logic [NREQ*CNT_BITS-1:0]   pkt_count_o
);

    localparam int unsigned IW = $clog2(NREQ);

    tx_state_e                      state_q, state_d;
    logic [NREQ-1:0]                grant_d;
    logic [IW-1:0]                  gidx_q, gidx_d;
    logic [IW-1:0]                  last_q, last_d;
    logic [NREQ-1:0][CNT_BITS-1:0]  cnt_q;
    logic [NREQ-1:0]                arb_gnt;
    logic [IW-1:0]                  arb_idx;
    logic                           pkt_done;

    udp_hdr_t                       hdr_sel;
    logic                           hvld_sel;
    logic [UDP_DATA_W-1:0]          data_sel;
    logic [UDP_KEEP_W-1:0]          keep_sel;
    logic                           last_sel;
    logic                           dvld_sel;

    rr_arbiter #(.N(NREQ)) u_rr (
        .req   (s_udphdr_tvalid),
        .last  (last_q),
        .gnt_c (arb_gnt),
        .idx_c (arb_idx)
    );

    // AND-OR mux on the one-hot grant; zero grant (IDLE, reset) yields all-zero outputs.
    always_comb begin
        hdr_sel  = '0;
        hvld_sel = 1'b0;
        data_sel = '0;
        keep_sel = '0;
        last_sel = 1'b0;
        dvld_sel = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_o[i]) begin
                hdr_sel  = s_udphdr_tdata[UDP_HDR_W*i +: UDP_HDR_W];
                hvld_sel = s_udphdr_tvalid[i];
                data_sel = s_udpdata_tdata[UDP_DATA_W*i +: UDP_DATA_W];
                keep_sel = s_udpdata_tkeep[UDP_KEEP_W*i +: UDP_KEEP_W];
                last_sel = s_udpdata_tlast[i];
                dvld_sel = s_udpdata_tvalid[i];
            end
        end
    end

    assign m_udphdr_tdata   = hdr_sel;
    assign m_udphdr_tvalid  = (state_q == HDR) && hvld_sel;
    assign s_udphdr_tready  = ((state_q == HDR) && m_udphdr_tready) ? grant_o : '0;
    assign m_udpdata_tdata  = data_sel;
    assign m_udpdata_tkeep  = keep_sel;
    assign m_udpdata_tlast  = last_sel;
    assign m_udpdata_tvalid = (state_q == DATA) && dvld_sel;
    assign s_udpdata_tready = ((state_q == DATA) && m_udpdata_tready) ? grant_o : '0;
    assign pkt_count_o      = cnt_q;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_o;
        gidx_d   = gidx_q;
        last_d   = last_q;
        pkt_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (|s_udphdr_tvalid) begin
                    grant_d = arb_gnt;
                    gidx_d  = arb_idx;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (m_udphdr_tvalid && m_udphdr_tready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (m_udpdata_tvalid && m_udpdata_tready && m_udpdata_tlast) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    last_d   = gidx_q;
                    pkt_done = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            grant_o <= '0;
            gidx_q  <= '0;
            last_q  <= IW'(NREQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_o <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            // Counter wraps modulo 2^CNT_BITS.
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (pkt_done && grant_o[i]) begin
                    cnt_q[i] <= cnt_q[i] + CNT_BITS'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_turf_udp_tx_arbiter.sv
// Directed bench for turf_udp_tx_arbiter: queue-driven AXI sources, logging sink, per-scenario tasks.
module tb_turf_udp_tx_arbiter;

    localparam int unsigned NREQ = 2;
    // Narrow counter so the wrap is reachable with real traffic.
    localparam int unsigned CNT_BITS = 4;

    logic                     aclk;
    logic                     aresetn;
    logic [NREQ*64-1:0]       s_udphdr_tdata;
    logic [NREQ-1:0]          s_udphdr_tvalid;
    logic [NREQ-1:0]          s_udphdr_tready;
    logic [NREQ*64-1:0]       s_udpdata_tdata;
    logic [NREQ*8-1:0]        s_udpdata_tkeep;
    logic [NREQ-1:0]          s_udpdata_tlast;
    logic [NREQ-1:0]          s_udpdata_tvalid;
    logic [NREQ-1:0]          s_udpdata_tready;
    logic [63:0]              m_udphdr_tdata;
    logic                     m_udphdr_tvalid;
    logic                     m_udphdr_tready;
    logic [63:0]              m_udpdata_tdata;
    logic [7:0]               m_udpdata_tkeep;
    logic                     m_udpdata_tlast;
    logic                     m_udpdata_tvalid;
    logic                     m_udpdata_tready;
    logic [NREQ-1:0]          grant_o;
    logic [NREQ*CNT_BITS-1:0] pkt_count_o;

    turf_udp_tx_arbiter #(.NREQ(NREQ), .CNT_BITS(CNT_BITS)) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .s_udphdr_tdata   (s_udphdr_tdata),
        .s_udphdr_tvalid  (s_udphdr_tvalid),
        .s_udphdr_tready  (s_udphdr_tready),
        .s_udpdata_tdata  (s_udpdata_tdata),
        .s_udpdata_tkeep  (s_udpdata_tkeep),
        .s_udpdata_tlast  (s_udpdata_tlast),
        .s_udpdata_tvalid (s_udpdata_tvalid),
        .s_udpdata_tready (s_udpdata_tready),
        .m_udphdr_tdata   (m_udphdr_tdata),
        .m_udphdr_tvalid  (m_udphdr_tvalid),
        .m_udphdr_tready  (m_udphdr_tready),
        .m_udpdata_tdata  (m_udpdata_tdata),
        .m_udpdata_tkeep  (m_udpdata_tkeep),
        .m_udpdata_tlast  (m_udpdata_tlast),
        .m_udpdata_tvalid (m_udpdata_tvalid),
        .m_udpdata_tready (m_udpdata_tready),
        .grant_o          (grant_o),
        .pkt_count_o      (pkt_count_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] hq [NREQ][$];
    logic [72:0] dq [NREQ][$];
    logic [64:0] got_h [$];
    logic [73:0] got_d [$];

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [63:0] mkhdr(input int r, input int tag);
        return {32'h0A000001 + 32'(r), 16'h1234 + 16'(tag), 16'h0010};
    endfunction

    function automatic logic [63:0] bdat(input int r, input int tag, input int b);
        return {8'(r), 8'(tag), 16'hBEEF, 32'(b)};
    endfunction

    task automatic drive_srcs();
        for (int r = 0; r < NREQ; r++) begin
            s_udphdr_tvalid[r]           = (hq[r].size() != 0);
            s_udphdr_tdata[64*r +: 64]   = (hq[r].size() != 0) ? hq[r][0] : 64'h0;
            s_udpdata_tvalid[r]          = (dq[r].size() != 0);
            {s_udpdata_tlast[r], s_udpdata_tkeep[8*r +: 8], s_udpdata_tdata[64*r +: 64]} =
                (dq[r].size() != 0) ? dq[r][0] : 73'h0;
        end
    endtask

    // Sources: pop on handshake, flush while in reset, present the new head just after the edge.
    initial begin
        s_udphdr_tdata   = '0;
        s_udphdr_tvalid  = '0;
        s_udpdata_tdata  = '0;
        s_udpdata_tkeep  = '0;
        s_udpdata_tlast  = '0;
        s_udpdata_tvalid = '0;
        forever begin
            @(posedge aclk);
            for (int r = 0; r < NREQ; r++) begin
                if (!aresetn) begin
                    hq[r].delete();
                    dq[r].delete();
                end else begin
                    if (s_udphdr_tvalid[r] && s_udphdr_tready[r]) hq[r].delete(0);
                    if (s_udpdata_tvalid[r] && s_udpdata_tready[r]) dq[r].delete(0);
                end
            end
            #1;
            drive_srcs();
        end
    end

    // Sink log: {grant index, header} and {grant index, last, keep, data}.
    always @(posedge aclk) begin
        if (aresetn) begin
            if (m_udphdr_tvalid && m_udphdr_tready)
                got_h.push_back({grant_o[1], m_udphdr_tdata});
            if (m_udpdata_tvalid && m_udpdata_tready)
                got_d.push_back({grant_o[1], m_udpdata_tlast, m_udpdata_tkeep, m_udpdata_tdata});
        end
    end

    task automatic load_pkt(input int r, input int tag, input int nb, input logic [7:0] lkeep);
        hq[r].push_back(mkhdr(r, tag));
        for (int b = 0; b < nb; b++)
            dq[r].push_back({(b == nb - 1), (b == nb - 1) ? lkeep : 8'hFF, bdat(r, tag, b)});
    endtask

    task automatic wait_idle(input string tag);
        int cyc = 0;
        while ((hq[0].size() != 0 || hq[1].size() != 0 || dq[0].size() != 0 ||
                dq[1].size() != 0 || grant_o != '0) && cyc < 500) begin
            @(posedge aclk);
            cyc++;
        end
        @(posedge aclk);
        #2;
        n_cmp++;
        if (cyc >= 500) begin
            n_bad++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", tag, cyc);
        end
    endtask

    task automatic apply_reset();
        m_udphdr_tready  = 1'b1;
        m_udpdata_tready = 1'b1;
        @(posedge aclk);
        #2;
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #2;
        aresetn = 1'b1;
        got_h.delete();
        got_d.delete();
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        m_udphdr_tready  = 1'b1;
        m_udpdata_tready = 1'b1;
        repeat (2) @(posedge aclk);
        #4;
        n_cmp++;
        if ({m_udphdr_tvalid, m_udpdata_tvalid, s_udphdr_tready, s_udpdata_tready, grant_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b, required all zero",
                     {m_udphdr_tvalid, m_udpdata_tvalid, s_udphdr_tready, s_udpdata_tready, grant_o});
        end
        n_cmp++;
        if ({m_udphdr_tdata, m_udpdata_tdata, m_udpdata_tkeep, m_udpdata_tlast, pkt_count_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: hdr %h data %h keep %h cnt %h, required zero",
                     m_udphdr_tdata, m_udpdata_tdata, m_udpdata_tkeep, pkt_count_o);
        end
        @(posedge aclk);
        #2;
        aresetn = 1'b1;
        @(posedge aclk);
        #4;
        n_cmp++;
        if (grant_o !== 2'b00 || m_udphdr_tvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: grant %b hvalid %b, required 00 0", grant_o, m_udphdr_tvalid);
        end
    endtask

    task automatic test_single();
        @(posedge aclk);
        #2;
        load_pkt(0, 0, 1, 8'hFF);
        @(posedge aclk);
        #4;
        n_cmp++;
        if (m_udphdr_tvalid !== 1'b0 || grant_o !== 2'b00) begin
            n_bad++;
            $display("FAIL single_c0: hvalid %b grant %b, required 0 00", m_udphdr_tvalid, grant_o);
        end
        @(posedge aclk);
        #4;
        n_cmp++;
        if (m_udphdr_tvalid !== 1'b1 || m_udphdr_tdata !== 64'h0A000001_1234_0010 ||
            grant_o !== 2'b01 || s_udphdr_tready !== 2'b01 || m_udpdata_tvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_hdr: hv %b hdr %h grant %b rdy %b dv %b, required 1 0a00000112340010 01 01 0",
                     m_udphdr_tvalid, m_udphdr_tdata, grant_o, s_udphdr_tready, m_udpdata_tvalid);
        end
        @(posedge aclk);
        #4;
        n_cmp++;
        if (m_udpdata_tvalid !== 1'b1 || m_udpdata_tdata !== bdat(0, 0, 0) || m_udpdata_tkeep !== 8'hFF ||
            m_udpdata_tlast !== 1'b1 || s_udpdata_tready !== 2'b01 || m_udphdr_tvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_data: dv %b data %h keep %h last %b rdy %b, required 1 %h ff 1 01",
                     m_udpdata_tvalid, m_udpdata_tdata, m_udpdata_tkeep, m_udpdata_tlast,
                     s_udpdata_tready, bdat(0, 0, 0));
        end
        @(posedge aclk);
        #4;
        n_cmp++;
        if (pkt_count_o !== 8'h01 || grant_o !== 2'b00) begin
            n_bad++;
            $display("FAIL single_done: cnt %h grant %b, required 01 00", pkt_count_o, grant_o);
        end
    endtask

    task automatic test_round_robin();
        int ord [6] = '{0, 1, 0, 1, 0, 1};
        logic [73:0] exp_d [$];
        int nb;
        apply_reset();
        for (int p = 0; p < 3; p++) begin
            load_pkt(0, p, p + 1, 8'hFF);
            load_pkt(1, p, 3 - p, 8'h3F);
        end
        wait_idle("rr");
        n_cmp++;
        if (got_h.size() != 6 || got_d.size() != 12) begin
            n_bad++;
            $display("FAIL rr_count: %0d hdrs %0d beats, required 6 12", got_h.size(), got_d.size());
        end
        for (int k = 0; k < 6; k++) begin
            nb = (ord[k] == 0) ? (k / 2 + 1) : (3 - k / 2);
            for (int b = 0; b < nb; b++)
                exp_d.push_back({1'(ord[k]), (b == nb - 1), (b == nb - 1 && ord[k] == 1) ? 8'h3F : 8'hFF,
                                 bdat(ord[k], k / 2, b)});
            n_cmp++;
            if (k >= got_h.size() || got_h[k] !== {1'(ord[k]), mkhdr(ord[k], k / 2)}) begin
                n_bad++;
                $display("FAIL rr_hdr%0d: got %h, required %h", k,
                         (k < got_h.size()) ? got_h[k] : 65'h0, {1'(ord[k]), mkhdr(ord[k], k / 2)});
            end
        end
        for (int k = 0; k < exp_d.size(); k++) begin
            n_cmp++;
            if (k >= got_d.size() || got_d[k] !== exp_d[k]) begin
                n_bad++;
                $display("FAIL rr_beat%0d: got %h, required %h", k,
                         (k < got_d.size()) ? got_d[k] : 74'h0, exp_d[k]);
            end
        end
        n_cmp++;
        if (pkt_count_o !== 8'h33) begin
            n_bad++;
            $display("FAIL rr_cnt: got %h, required 33", pkt_count_o);
        end
    endtask

    task automatic test_stall();
        int cyc = 0;
        got_h.delete();
        got_d.delete();
        load_pkt(1, 7, 4, 8'h0F);
        while (got_d.size() < 1 && cyc < 50) begin
            @(posedge aclk);
            #2;
            cyc++;
        end
        m_udpdata_tready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            @(posedge aclk);
            #4;
            n_cmp++;
            if (m_udpdata_tvalid !== 1'b1 || m_udpdata_tdata !== bdat(1, 7, 1) ||
                m_udpdata_tkeep !== 8'hFF || m_udpdata_tlast !== 1'b0 || s_udpdata_tready !== 2'b00) begin
                n_bad++;
                $display("FAIL stall_c%0d: dv %b data %h keep %h last %b rdy %b, required 1 %h ff 0 00",
                         s, m_udpdata_tvalid, m_udpdata_tdata, m_udpdata_tkeep, m_udpdata_tlast,
                         s_udpdata_tready, bdat(1, 7, 1));
            end
        end
        n_cmp++;
        if (got_d.size() != 1) begin
            n_bad++;
            $display("FAIL stall_held: %0d beats accepted, required 1", got_d.size());
        end
        m_udpdata_tready = 1'b1;
        wait_idle("stall");
        for (int b = 0; b < 4; b++) begin
            n_cmp++;
            if (b >= got_d.size() ||
                got_d[b] !== {1'b1, (b == 3), (b == 3) ? 8'h0F : 8'hFF, bdat(1, 7, b)}) begin
                n_bad++;
                $display("FAIL stall_beat%0d: got %h, required %h", b, (b < got_d.size()) ? got_d[b] : 74'h0,
                         {1'b1, (b == 3), (b == 3) ? 8'h0F : 8'hFF, bdat(1, 7, b)});
            end
        end
        n_cmp++;
        if (pkt_count_o !== 8'h43) begin
            n_bad++;
            $display("FAIL stall_cnt: got %h, required 43", pkt_count_o);
        end
    endtask

    task automatic test_data_first();
        got_h.delete();
        got_d.delete();
        @(posedge aclk);
        #2;
        dq[0].push_back({1'b0, 8'hFF, bdat(0, 9, 0)});
        dq[0].push_back({1'b1, 8'h01, bdat(0, 9, 1)});
        for (int c = 0; c < 3; c++) begin
            @(posedge aclk);
            #4;
            n_cmp++;
            if (s_udpdata_tvalid[0] !== 1'b1 || s_udpdata_tready !== 2'b00 ||
                m_udpdata_tvalid !== 1'b0 || got_d.size() != 0) begin
                n_bad++;
                $display("FAIL early_c%0d: src_v %b rdy %b m_v %b beats %0d, required 1 00 0 0",
                         c, s_udpdata_tvalid[0], s_udpdata_tready, m_udpdata_tvalid, got_d.size());
            end
        end
        hq[0].push_back(mkhdr(0, 9));
        wait_idle("early");
        n_cmp++;
        if (got_h.size() != 1 || got_h[0] !== {1'b0, mkhdr(0, 9)}) begin
            n_bad++;
            $display("FAIL early_hdr: %0d hdrs, first %h, required 1 %h", got_h.size(),
                     (got_h.size() != 0) ? got_h[0] : 65'h0, {1'b0, mkhdr(0, 9)});
        end
        n_cmp++;
        if (got_d.size() != 2 || got_d[0] !== {2'b00, 8'hFF, bdat(0, 9, 0)} ||
            got_d[1] !== {2'b01, 8'h01, bdat(0, 9, 1)}) begin
            n_bad++;
            $display("FAIL early_data: %0d beats, required 2 intact beats %h %h", got_d.size(),
                     bdat(0, 9, 0), bdat(0, 9, 1));
        end
    endtask

    task automatic test_wrap();
        for (int p = 0; p < 11; p++) load_pkt(0, p, 1, 8'hFF);
        wait_idle("wrap_fill");
        n_cmp++;
        if (pkt_count_o !== 8'h4F) begin
            n_bad++;
            $display("FAIL wrap_full: got %h, required 4f", pkt_count_o);
        end
        load_pkt(0, 20, 1, 8'hFF);
        wait_idle("wrap");
        n_cmp++;
        if (pkt_count_o !== 8'h40) begin
            n_bad++;
            $display("FAIL wrap_zero: got %h, required 40", pkt_count_o);
        end
    endtask

    task automatic test_reset_mid_packet();
        int cyc = 0;
        got_h.delete();
        got_d.delete();
        load_pkt(1, 3, 4, 8'hFF);
        while (got_d.size() < 1 && cyc < 50) begin
            @(posedge aclk);
            #2;
            cyc++;
        end
        n_cmp++;
        if (m_udpdata_tvalid !== 1'b1 || grant_o !== 2'b10) begin
            n_bad++;
            $display("FAIL midrst_pre: dv %b grant %b, required 1 10", m_udpdata_tvalid, grant_o);
        end
        aresetn = 1'b0;
        #1;
        n_cmp++;
        if ({m_udphdr_tvalid, m_udpdata_tvalid, s_udphdr_tready, s_udpdata_tready, grant_o} !== '0 ||
            pkt_count_o !== '0 || m_udpdata_tdata !== '0) begin
            n_bad++;
            $display("FAIL midrst_now: hv %b dv %b hr %b dr %b grant %b cnt %h data %h, required all zero",
                     m_udphdr_tvalid, m_udpdata_tvalid, s_udphdr_tready, s_udpdata_tready, grant_o,
                     pkt_count_o, m_udpdata_tdata);
        end
        repeat (2) @(posedge aclk);
        #2;
        aresetn = 1'b1;
        got_h.delete();
        got_d.delete();
        load_pkt(0, 4, 1, 8'hFF);
        load_pkt(1, 4, 1, 8'hFF);
        wait_idle("midrst");
        n_cmp++;
        if (got_h.size() != 2 || got_h[0] !== {1'b0, mkhdr(0, 4)} || got_h[1] !== {1'b1, mkhdr(1, 4)}) begin
            n_bad++;
            $display("FAIL midrst_order: %0d hdrs, first %h, required 2 starting %h", got_h.size(),
                     (got_h.size() != 0) ? got_h[0] : 65'h0, {1'b0, mkhdr(0, 4)});
        end
        n_cmp++;
        if (pkt_count_o !== 8'h11) begin
            n_bad++;
            $display("FAIL midrst_cnt: got %h, required 11", pkt_count_o);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        aresetn          = 1'b0;
        m_udphdr_tready  = 1'b1;
        m_udpdata_tready = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_data_first();
        test_wrap();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
